// File: rtl/register_file_if.sv
// register_file_if: groups the RoB-facing issue/commit/clear strobes and the
// decoder-facing source-operand read ports of the architectural register file.
//   master : RoB + decoder side. It drives clear, issue, commit and rs1/rs2,
//            and it receives the per-source busy/dep/value.
//   slave  : register file side.
interface register_file_if #(
  parameter int ROB_ADDR = 4
);
  logic                clear;
  logic                issue_valid;
  logic [4:0]          issue_rd;
  logic [ROB_ADDR-1:0] issue_dep;
  logic                commit_valid;
  logic [4:0]          commit_rd;
  logic [ROB_ADDR-1:0] commit_robid;
  logic [31:0]         commit_value;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic                rs1_busy;
  logic [ROB_ADDR-1:0] rs1_dep;
  logic [31:0]         rs1_value;
  logic                rs2_busy;
  logic [ROB_ADDR-1:0] rs2_dep;
  logic [31:0]         rs2_value;

  modport master (
    output clear, issue_valid, issue_rd, issue_dep,
    output commit_valid, commit_rd, commit_robid, commit_value,
    output rs1, rs2,
    input  rs1_busy, rs1_dep, rs1_value, rs2_busy, rs2_dep, rs2_value
  );

  modport slave (
    input  clear, issue_valid, issue_rd, issue_dep,
    input  commit_valid, commit_rd, commit_robid, commit_value,
    input  rs1, rs2,
    output rs1_busy, rs1_dep, rs1_value, rs2_busy, rs2_dep, rs2_value
  );
endinterface

// File: rtl/register_file.sv
// register_file: architectural register file with rename tags. It sits
// downstream of the reorder buffer.
//   clk_in : system clock
//   rst_in : synchronous active-high reset. It clears all values and tags,
//            and it does not depend on rdy_in.
//   rdy_in : global enable. When it is low, all state holds. Reads stay live.
//   bus    : slave side of register_file_if. It carries issue, commit and
//            clear from the RoB, plus two combinational source read ports
//            for the decoder.
module register_file #(
  parameter int ROB_ADDR = 4,
  parameter int REG_NUM  = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  register_file_if.slave  bus
);

  typedef struct packed {
    logic                busy;
    logic [ROB_ADDR-1:0] dep;
    logic [31:0]         value;
  } rd_port_t;

  logic [31:0]         value_q [REG_NUM];
  logic                busy_q  [REG_NUM];
  logic [ROB_ADDR-1:0] dep_q   [REG_NUM];
  logic [31:0]         value_d [REG_NUM];
  logic                busy_d  [REG_NUM];
  logic [ROB_ADDR-1:0] dep_d   [REG_NUM];

  rd_port_t rd1_s;
  rd_port_t rd2_s;

  // A read port sees rename state as of the start of the cycle. A commit
  // whose tag matches the outstanding producer is forwarded as ready. A
  // commit to the same register with a stale tag forwards only its value.
  function automatic rd_port_t read_port(
    input logic [4:0]          rs,
    input logic                s_busy,
    input logic [ROB_ADDR-1:0] s_dep,
    input logic [31:0]         s_val,
    input logic                c_valid,
    input logic [4:0]          c_rd,
    input logic [ROB_ADDR-1:0] c_rob,
    input logic [31:0]         c_val
  );
    rd_port_t p;
    p.busy  = s_busy;
    p.dep   = s_busy ? s_dep : {ROB_ADDR{1'b0}};
    p.value = s_val;
    if (rs == 5'd0) begin
      p = '{busy: 1'b0, dep: {ROB_ADDR{1'b0}}, value: 32'd0};
    end else if (c_valid && (c_rd == rs)) begin
      p.value = c_val;
      if (s_busy && (s_dep == c_rob)) begin
        p.busy = 1'b0;
        p.dep  = {ROB_ADDR{1'b0}};
      end else begin
        p.busy = p.busy;
      end
    end else begin
      p.value = p.value;
    end
    return p;
  endfunction

  // Next-state computation. Commit always writes the value. Clear beats
  // issue for the rename tags. Issue beats commit for the rename tags.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    dep_d   = dep_q;
    if (rdy_in) begin
      if (bus.commit_valid && (bus.commit_rd != 5'd0)) begin
        value_d[bus.commit_rd] = bus.commit_value;
        if (busy_q[bus.commit_rd] && (dep_q[bus.commit_rd] == bus.commit_robid)) begin
          busy_d[bus.commit_rd] = 1'b0;
          dep_d[bus.commit_rd]  = {ROB_ADDR{1'b0}};
        end else begin
          busy_d[bus.commit_rd] = busy_q[bus.commit_rd];
        end
      end else begin
        value_d = value_d;
      end
      if (bus.clear) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_d[i] = 1'b0;
          dep_d[i]  = {ROB_ADDR{1'b0}};
        end
      end else if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
        busy_d[bus.issue_rd] = 1'b1;
        dep_d[bus.issue_rd]  = bus.issue_dep;
      end else begin
        busy_d = busy_d;
      end
    end else begin
      value_d = value_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= 32'd0;
        busy_q[i]  <= 1'b0;
        dep_q[i]   <= {ROB_ADDR{1'b0}};
      end
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      dep_q   <= dep_d;
    end
  end

  // Combinational source-operand read ports.
  always_comb begin
    rd1_s = read_port(bus.rs1, busy_q[bus.rs1], dep_q[bus.rs1], value_q[bus.rs1],
                      bus.commit_valid, bus.commit_rd, bus.commit_robid, bus.commit_value);
    rd2_s = read_port(bus.rs2, busy_q[bus.rs2], dep_q[bus.rs2], value_q[bus.rs2],
                      bus.commit_valid, bus.commit_rd, bus.commit_robid, bus.commit_value);
  end

  assign bus.rs1_busy  = rd1_s.busy;
  assign bus.rs1_dep   = rd1_s.dep;
  assign bus.rs1_value = rd1_s.value;
  assign bus.rs2_busy  = rd2_s.busy;
  assign bus.rs2_dep   = rd2_s.dep;
  assign bus.rs2_value = rd2_s.value;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios followed by randomized traffic for
// register_file. The traffic is checked against an array-based reference model.
module tb_register_file;

  logic clk;
  logic rst;
  logic rdy;
  int   vectors;
  int   miscompares;

  register_file_if #(.ROB_ADDR(4)) bus ();

  register_file #(.ROB_ADDR(4), .REG_NUM(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural state kept as plain arrays.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_dep  [32];

  function automatic logic [36:0] pk(input logic b, input logic [3:0] d, input logic [31:0] v);
    return {b, d, v};
  endfunction

  function automatic logic [36:0] r1();
    return {bus.rs1_busy, bus.rs1_dep, bus.rs1_value};
  endfunction

  function automatic logic [36:0] r2();
    return {bus.rs2_busy, bus.rs2_dep, bus.rs2_value};
  endfunction

  // Expected read result derived from the read-port rules.
  function automatic logic [36:0] mread(input logic [4:0] rs);
    logic [31:0] v;
    if (rs == 5'd0) return 37'd0;
    if (bus.commit_valid && bus.commit_rd == rs && m_busy[rs] && m_dep[rs] == bus.commit_robid)
      return {1'b0, 4'd0, bus.commit_value};
    v = (bus.commit_valid && bus.commit_rd == rs) ? bus.commit_value : m_val[rs];
    return {m_busy[rs], (m_busy[rs] ? m_dep[rs] : 4'd0), v};
  endfunction

  task automatic idle();
    bus.clear = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd = 5'd0;
    bus.issue_dep = 4'd0;
    bus.commit_valid = 1'b0;
    bus.commit_rd = 5'd0;
    bus.commit_robid = 4'd0;
    bus.commit_value = 32'd0;
  endtask

  // Advance one clock edge and apply the update rules to the model.
  task automatic tick();
    logic match;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0; m_busy[i] = 1'b0; m_dep[i] = 4'd0;
      end
    end else if (rdy) begin
      if (bus.commit_valid && bus.commit_rd != 5'd0) begin
        match = m_busy[bus.commit_rd] && (m_dep[bus.commit_rd] == bus.commit_robid);
        m_val[bus.commit_rd] = bus.commit_value;
        if (match) begin
          m_busy[bus.commit_rd] = 1'b0; m_dep[bus.commit_rd] = 4'd0;
        end
      end
      if (bus.clear) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_dep[i] = 4'd0;
        end
      end else if (bus.issue_valid && bus.issue_rd != 5'd0) begin
        m_busy[bus.issue_rd] = 1'b1; m_dep[bus.issue_rd] = bus.issue_dep;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [36:0] got;
    rst = 1'b1; rdy = 1'b0; idle(); bus.rs1 = 5'd5; bus.rs2 = 5'd0;
    tick();
    rst = 1'b0; rdy = 1'b1; #1;
    got = r1(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL reset_rs1: got %h expected %h", got, 37'd0); end
    got = r2(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL reset_rs2: got %h expected %h", got, 37'd0); end
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd0; bus.commit_value = 32'hDEAD;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.issue_dep = 4'd3; bus.rs1 = 5'd0; #1;
    got = r1(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL x0_same_cycle: got %h expected %h", got, 37'd0); end
    tick(); idle(); #1;
    got = r1(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL x0_after: got %h expected %h", got, 37'd0); end
  endtask

  task automatic test_bypass();
    logic [36:0] got, exp;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.issue_dep = 4'd2;
    tick(); idle(); bus.rs1 = 5'd3; #1;
    got = r1(); exp = pk(1'b1, 4'd2, 32'd0); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL issue_busy: got %h expected %h", got, exp); end
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd3; bus.commit_robid = 4'd2; bus.commit_value = 32'h1234; #1;
    got = r1(); exp = pk(1'b0, 4'd0, 32'h1234); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL commit_bypass: got %h expected %h", got, exp); end
    tick(); idle(); #1;
    got = r1(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL commit_stored: got %h expected %h", got, exp); end
  endtask

  task automatic test_stale_commit();
    logic [36:0] got, exp;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.issue_dep = 4'd1; tick();
    bus.issue_dep = 4'd6; tick(); idle();
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd4; bus.commit_robid = 4'd1; bus.commit_value = 32'd7;
    bus.rs1 = 5'd4; #1;
    got = r1(); exp = pk(1'b1, 4'd6, 32'd7); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stale_bypass: got %h expected %h", got, exp); end
    tick(); idle(); #1;
    got = r1(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stale_stored: got %h expected %h", got, exp); end
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd4; bus.commit_robid = 4'd6; bus.commit_value = 32'd9;
    tick(); idle(); #1;
    got = r1(); exp = pk(1'b0, 4'd0, 32'd9); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL young_commit: got %h expected %h", got, exp); end
  endtask

  task automatic test_issue_commit_same();
    logic [36:0] got, exp;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.issue_dep = 4'd3; tick();
    bus.issue_dep = 4'd5;
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd8; bus.commit_robid = 4'd3; bus.commit_value = 32'hAA;
    bus.rs2 = 5'd8; #1;
    got = r2(); exp = pk(1'b0, 4'd0, 32'hAA); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL same_cycle_read: got %h expected %h", got, exp); end
    tick(); idle(); #1;
    got = r2(); exp = pk(1'b1, 4'd5, 32'hAA); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL issue_wins: got %h expected %h", got, exp); end
  endtask

  task automatic test_clear();
    logic [36:0] got, exp;
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd2; bus.commit_value = 32'h55; tick(); idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd1;  bus.issue_dep = 4'd1; tick();
    bus.issue_rd = 5'd2;  bus.issue_dep = 4'd2; tick();
    bus.issue_rd = 5'd10; bus.issue_dep = 4'd3; tick();
    bus.clear = 1'b1; bus.issue_rd = 5'd11; bus.issue_dep = 4'd4; tick(); idle();
    bus.rs1 = 5'd1; bus.rs2 = 5'd2; #1;
    got = r1(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL clear_r1: got %h expected %h", got, 37'd0); end
    got = r2(); exp = pk(1'b0, 4'd0, 32'h55); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL clear_r2: got %h expected %h", got, exp); end
    bus.rs1 = 5'd10; bus.rs2 = 5'd11; #1;
    got = r1(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL clear_r10: got %h expected %h", got, 37'd0); end
    got = r2(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL clear_r11: got %h expected %h", got, 37'd0); end
  endtask

  task automatic test_rdy();
    logic [36:0] got, exp;
    rdy = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6; bus.issue_dep = 4'd7;
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd7; bus.commit_robid = 4'd0; bus.commit_value = 32'd5;
    tick(); idle(); bus.rs1 = 5'd6; bus.rs2 = 5'd7; #1;
    got = r1(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL rdy_hold_r6: got %h expected %h", got, 37'd0); end
    got = r2(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL rdy_hold_r7: got %h expected %h", got, 37'd0); end
    rdy = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6; bus.issue_dep = 4'd7;
    bus.commit_valid = 1'b1; bus.commit_rd = 5'd7; bus.commit_robid = 4'd0; bus.commit_value = 32'd5; #1;
    got = r1(); vectors++;
    if (got !== 37'd0) begin miscompares++; $display("FAIL rdy_pre_edge: got %h expected %h", got, 37'd0); end
    tick(); idle(); #1;
    got = r1(); exp = pk(1'b1, 4'd7, 32'd0); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rdy_issue: got %h expected %h", got, exp); end
    got = r2(); exp = pk(1'b0, 4'd0, 32'd5); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rdy_commit: got %h expected %h", got, exp); end
  endtask

  task automatic test_random();
    logic [36:0] got, exp;
    logic [4:0]  crd;
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 7) != 0);
      bus.clear = ($urandom_range(0, 19) == 0);
      bus.issue_valid = $urandom_range(0, 1);
      bus.issue_rd = 5'($urandom_range(0, 7));
      bus.issue_dep = 4'($urandom);
      crd = 5'($urandom_range(0, 7));
      bus.commit_valid = $urandom_range(0, 1);
      bus.commit_rd = crd;
      bus.commit_robid = ($urandom_range(0, 1) == 1) ? m_dep[crd] : 4'($urandom);
      bus.commit_value = $urandom;
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = ($urandom_range(0, 3) == 0) ? crd : 5'($urandom_range(0, 7));
      #1;
      got = r1(); exp = mread(bus.rs1); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL rand_rs1 n=%0d rs=%0d: got %h expected %h", n, bus.rs1, got, exp); end
      got = r2(); exp = mread(bus.rs2); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL rand_rs2 n=%0d rs=%0d: got %h expected %h", n, bus.rs2, got, exp); end
      tick();
    end
    idle(); rdy = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; rdy = 1'b1; idle(); bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    @(negedge clk);
    test_reset();
    test_bypass();
    test_stale_commit();
    test_issue_commit_same();
    test_clear();
    test_rdy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
